// File: rtl/sync_corr_locker.sv
// sync_corr_locker: sliding-window sync-marker correlator with SEARCH/VERIFY/LOCK
// frame acquisition, flywheel tolerance and polarity correction of the bit stream.
module sync_corr_locker #(
   parameter logic [63:0] SYNC_WORD  = 64'h1ACFFC1D,
   parameter int unsigned SYNC_LEN   = 32,
   parameter int unsigned FRAME_BITS = 8192,
   parameter int unsigned THRESH     = 29,
   parameter int unsigned VERIFY_CNT = 2,
   parameter int unsigned FLYWHEEL   = 3,
   localparam int unsigned CW = $clog2(SYNC_LEN + 1)
) (
   input  logic          clk,
   input  logic          sys_rst,
   input  logic          bit_in,
   input  logic          valid_in,
   output logic          valid_out,
   output logic          bit_out,
   output logic          frame_start,
   output logic          locked,
   output logic          inverted,
   output logic [CW-1:0] corr_val
);
   localparam int unsigned PW = $clog2(FRAME_BITS);
   localparam int unsigned HW = $clog2(VERIFY_CNT + 1);
   localparam int unsigned MW = $clog2(FLYWHEEL + 2);

   typedef enum logic [1:0] {SEARCH, VERIFY, LOCK} state_t;

   state_t                r_st;
   logic [SYNC_LEN-2:0]   r_win;
   logic [CW-1:0]         r_fill;
   logic [PW-1:0]         r_pos;
   logic [HW-1:0]         r_hits;
   logic [MW-1:0]         r_miss;
   logic                  r_vout, r_bout, r_fs, r_locked, r_inv;
   logic [CW-1:0]         r_cv;

   logic [SYNC_LEN-1:0]   w_win, w_x;
   logic [CW-1:0]         w_m, w_mi;
   logic                  w_full, w_mt, w_mit, w_acq, w_inv_nx, w_hit, w_bnd;
   logic [PW-1:0]         w_pos_nx;

   // window includes the bit being presented this cycle
   assign w_win = {r_win, bit_in};
   assign w_x   = w_win ^ SYNC_WORD[SYNC_LEN-1:0];

   always_comb begin
      w_mi = '0;
      for (int k = 0; k < SYNC_LEN; k++) w_mi = w_mi + CW'(w_x[k]);
   end

   assign w_m      = CW'(SYNC_LEN) - w_mi;
   assign w_full   = r_fill >= CW'(SYNC_LEN - 1);
   assign w_mt     = w_full && (w_m >= CW'(THRESH));
   assign w_mit    = w_full && (w_mi >= CW'(THRESH));
   assign w_acq    = (r_st == SEARCH) && (w_mt || w_mit);
   assign w_inv_nx = w_acq ? !w_mt : r_inv;
   assign w_hit    = r_inv ? w_mit : w_mt;
   assign w_bnd    = r_pos == PW'(FRAME_BITS - 1);
   assign w_pos_nx = w_bnd ? '0 : r_pos + PW'(1);

   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_st     <= SEARCH;
         r_win    <= '0;
         r_fill   <= '0;
         r_pos    <= '0;
         r_hits   <= '0;
         r_miss   <= '0;
         r_vout   <= 1'b0;
         r_bout   <= 1'b0;
         r_fs     <= 1'b0;
         r_locked <= 1'b0;
         r_inv    <= 1'b0;
         r_cv     <= '0;
      end else begin
         r_vout <= valid_in;
         r_fs   <= 1'b0;
         if (valid_in) begin
            r_win  <= w_win[SYNC_LEN-2:0];
            r_fill <= (r_fill == CW'(SYNC_LEN)) ? r_fill : r_fill + CW'(1);
            r_cv   <= (w_m >= w_mi) ? w_m : w_mi;
            r_bout <= bit_in ^ w_inv_nx;
            r_inv  <= w_inv_nx;
            case (r_st)
               SEARCH: if (w_acq) begin
                  r_pos    <= '0;
                  r_hits   <= HW'(1);
                  r_miss   <= '0;
                  r_st     <= (VERIFY_CNT == 1) ? LOCK : VERIFY;
                  r_locked <= VERIFY_CNT == 1;
                  r_fs     <= VERIFY_CNT == 1;
               end
               VERIFY: begin
                  r_pos <= w_pos_nx;
                  if (w_bnd && w_hit) begin
                     r_hits <= r_hits + HW'(1);
                     if (r_hits == HW'(VERIFY_CNT - 1)) begin
                        r_st     <= LOCK;
                        r_locked <= 1'b1;
                        r_fs     <= 1'b1;
                        r_miss   <= '0;
                     end
                  end else if (w_bnd) r_st <= SEARCH;
               end
               LOCK: begin
                  r_pos <= w_pos_nx;
                  if (w_bnd) begin
                     r_miss <= w_hit ? '0 : r_miss + MW'(1);
                     if (!w_hit && r_miss >= MW'(FLYWHEEL)) begin
                        r_st     <= SEARCH;
                        r_locked <= 1'b0;
                     end else r_fs <= 1'b1;
                  end
               end
               default: r_st <= SEARCH;
            endcase
         end
      end
   end

   assign valid_out   = r_vout;
   assign bit_out     = r_bout;
   assign frame_start = r_fs;
   assign locked      = r_locked;
   assign inverted    = r_inv;
   assign corr_val    = r_cv;
endmodule

// File: tb/tb_sync_corr_locker.sv
// tb_sync_corr_locker: directed vectors for the sync correlator/locker with FRAME_BITS=64.
module tb_sync_corr_locker;
   localparam logic [31:0] MARK = 32'h1ACFFC1D;
   localparam logic [31:0] RND  = 32'h3C5A96E1;

   logic       clk = 1'b0, sys_rst = 1'b1, bit_in = 1'b0, valid_in = 1'b0;
   logic       valid_out, bit_out, frame_start, locked, inverted;
   logic [5:0] corr_val;
   int         n_cmp = 0, n_err = 0, fs_cnt = 0;

   sync_corr_locker #(.FRAME_BITS(64)) dut (
      .clk(clk), .sys_rst(sys_rst), .bit_in(bit_in), .valid_in(valid_in),
      .valid_out(valid_out), .bit_out(bit_out), .frame_start(frame_start),
      .locked(locked), .inverted(inverted), .corr_val(corr_val)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic b);
      bit_in   = b;
      valid_in = 1'b1;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      if (frame_start) fs_cnt++;
   endtask

   task automatic idle(input int n);
      valid_in = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 31; i >= 0; i--) send(w[i]);
   endtask

   task automatic send_word_gap(input logic [31:0] w);
      for (int i = 31; i >= 0; i--) begin
         send(w[i]);
         if ($urandom_range(0, 3) == 0) begin
            idle(1 + $urandom_range(0, 2));
            check("gap_vout_fs", {valid_out, frame_start}, 0);
         end
      end
   endtask

   task automatic do_reset();
      sys_rst  = 1'b1;
      valid_in = 1'b0;
      bit_in   = 1'b0;
      @(posedge clk);
      #1;
      sys_rst = 1'b0;
      fs_cnt  = 0;
   endtask

   initial begin
      // reset and idle
      #3;
      check("rst_outs", {valid_out, bit_out, frame_start, locked, inverted, corr_val}, 0);
      do_reset();
      for (int i = 0; i < 4; i++) begin
         idle(2);
         check("idle_outs", {valid_out, bit_out, frame_start, locked, inverted, corr_val}, 0);
      end

      // true-polarity acquisition and lock
      send_word(MARK);
      check("m1_corr", corr_val, 32);
      check("m1_inv", inverted, 0);
      check("m1_lock_fs", {locked, frame_start}, 0);
      send_word(RND);
      check("verify_fs_cnt", fs_cnt, 0);
      send_word(MARK);
      check("m2_corr", corr_val, 32);
      check("m2_lock_fs", {locked, frame_start}, 2'b11);
      check("m2_fs_cnt", fs_cnt, 1);

      // flywheel: three corrupted markers tolerated, fourth drops lock
      for (int k = 0; k < 3; k++) begin
         fs_cnt = 0;
         send_word(RND);
         send_word(MARK ^ 32'h0000FF00);
         check("fly_lock_fs", {locked, frame_start}, 2'b11);
         check("fly_fs_cnt", fs_cnt, 1);
      end
      send_word(RND);
      send_word(MARK ^ 32'h0000FF00);
      check("fly_drop", {locked, frame_start}, 0);

      // inverted stream
      do_reset();
      send_word(~MARK);
      check("inv_flag", inverted, 1);
      check("inv_corr", corr_val, 32);
      check("inv_bout_m", bit_out, MARK[0]);
      for (int i = 31; i >= 0; i--) begin
         send(~RND[i]);
         check("inv_bout", bit_out, RND[i]);
      end
      send_word(~MARK);
      check("inv_lock_fs", {locked, frame_start, inverted}, 3'b111);
      check("inv_bout_m2", bit_out, MARK[0]);

      // threshold edge: 3 errors hit, 4 errors miss
      do_reset();
      send_word(MARK ^ 32'h7);
      check("e3_corr", corr_val, 29);
      send_word(RND);
      send_word(MARK);
      check("e3_lock", {locked, frame_start}, 2'b11);
      do_reset();
      send_word(MARK ^ 32'hF);
      check("e4_corr", corr_val, 28);
      send_word(RND);
      send_word(MARK);
      check("e4_corr2", corr_val, 32);
      check("e4_nolock", {locked, frame_start}, 0);

      // valid gaps while locked, then asynchronous reset mid-frame
      do_reset();
      send_word_gap(MARK);
      send_word_gap(RND);
      send_word_gap(MARK);
      check("gap_lock1", {locked, frame_start}, 2'b11);
      fs_cnt = 0;
      send_word_gap(RND);
      send_word_gap(MARK);
      check("gap_lock2", {locked, frame_start}, 2'b11);
      check("gap_fs_cnt", fs_cnt, 1);
      for (int i = 31; i >= 27; i--) send(RND[i]);
      #2;
      sys_rst = 1'b1;
      #1;
      check("async_rst", {valid_out, bit_out, frame_start, locked, inverted, corr_val}, 0);
      @(posedge clk);
      #1;
      sys_rst = 1'b0;
      fs_cnt  = 0;
      for (int i = 30; i >= 0; i--) send(MARK[i]);
      check("fill_corr", corr_val, 32);
      send_word(RND);
      send_word(MARK);
      check("fill_nolock", {locked, frame_start}, 0);
      check("fill_fs_cnt", fs_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule

// File: doc/sync_corr_locker.md
SYNC_CORR_LOCKER -- requirements
Module: sync_corr_locker

Interface
REQ-001 SHALL have parameter SYNC_WORD, default 32'h1ACFFC1D, attached sync marker; MSB is first in time.
REQ-002 SHALL have parameter SYNC_LEN, default 32, marker length in bits (8..64).
REQ-003 SHALL have parameter FRAME_BITS, default 8192, valid bits from one marker's last bit to the next, marker included.
REQ-004 SHALL have parameter THRESH, default 29, minimum matching bits for a hit.
REQ-005 SHALL have parameter VERIFY_CNT, default 2, consecutive hits (first included) required to lock.
REQ-006 SHALL have parameter FLYWHEEL, default 3, consecutive misses tolerated while locked.
REQ-007 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-008 SHALL have port sys_rst, input, 1, reset; asynchronous, active-high.
REQ-009 SHALL have port bit_in, input, 1, hard-decision channel bit.
REQ-010 SHALL have port valid_in, input, 1, qualifies bit_in for one cycle.
REQ-011 SHALL have port valid_out, output, 1, qualifies bit_out.
REQ-012 SHALL have port bit_out, output, 1, polarity-corrected bit.
REQ-013 SHALL have port frame_start, output, 1, pulse with valid_out on the marker's last bit at an accepted frame boundary.
REQ-014 SHALL have port locked, output, 1, high while in LOCK.
REQ-015 SHALL have port inverted, output, 1, polarity of the current/last acquisition.
REQ-016 SHALL have port corr_val, output, $clog2(SYNC_LEN+1), max(true match, inverse match) for the latest valid bit.

Function
REQ-017 SHALL shift bit_in into a SYNC_LEN-bit register (new bit at LSB) only on valid_in; no state changes when valid_in=0.
REQ-018 SHALL compute m = SYNC_LEN - popcount(window ^ SYNC_WORD) and mi = SYNC_LEN - m, the window including the current bit.
REQ-019 SHALL suppress all hits until SYNC_LEN valid bits have arrived since reset (fill counter saturates).
REQ-020 SHALL register valid_out, bit_out = bit_in XOR inverted, corr_val and frame_start with exactly one cycle latency from valid_in.
REQ-021 SHALL hold valid_out=0 and frame_start=0 in cycles following valid_in=0; bit_out and corr_val hold their values.
REQ-022 SHALL implement states SEARCH, VERIFY, LOCK plus a position counter pos (0..FRAME_BITS-1) advanced per valid bit; a boundary occurs when pos wraps to 0.
REQ-023 SEARCH: on m>=THRESH set inverted=0, on mi>=THRESH (and m<THRESH) set inverted=1; either goes to VERIFY with pos=0 and hits=1, or straight to LOCK if VERIFY_CNT=1; true polarity wins when both qualify.
REQ-024 VERIFY: hits off boundaries are ignored; at a boundary, a hit (match in recorded polarity >=THRESH) increments hits and enters LOCK when hits==VERIFY_CNT; a miss returns to SEARCH and the same bit is NOT re-evaluated for acquisition.
REQ-025 LOCK: at each boundary a hit clears misses; a miss increments misses; misses>FLYWHEEL returns to SEARCH with locked=0, otherwise LOCK holds.
REQ-026 SHALL pulse frame_start at every boundary where the post-update state is LOCK, including flywheel misses and the VERIFY->LOCK transition bit.
REQ-027 inverted SHALL not change outside SEARCH acquisition; bit_out uses the value of inverted after update for the same bit.
REQ-028 locked SHALL equal (state==LOCK) registered on the same edge as frame_start.
REQ-029 Counters SHALL be sized to never overflow: pos $clog2(FRAME_BITS), hits $clog2(VERIFY_CNT+1), misses $clog2(FLYWHEEL+2).

Reset
REQ-030 On sys_rst=1, immediately and irrespective of clk: state=SEARCH, window, fill counter, pos, hits, misses=0; all outputs=0.
REQ-031 Reset asserted mid-LOCK SHALL discard lock; after release no hit until SYNC_LEN fresh valid bits.

Verification (bench params FRAME_BITS=64, others default)
REQ-032 Reset, then idle -> all outputs 0, locked=0 throughout.
REQ-033 Stream 0x1ACFFC1D, 32 random bits, 0x1ACFFC1D (MSB first, valid_in continuous) -> corr_val=32 after each marker; locked=1 and frame_start=1 one cycle after the 2nd marker's last bit; no frame_start after the first.
REQ-034 Same stream bit-inverted -> inverted=1 from first marker; bit_out equals uninverted stream; lock as in REQ-033.
REQ-035 Locked, then 3 consecutive corrupted markers -> locked stays 1, frame_start pulses each boundary; 4th corrupted -> locked=0, no frame_start on that bit.
REQ-036 Marker with 3 bit errors -> corr_val=29, hit; 4 errors -> corr_val=28, no hit, remains SEARCH.
REQ-037 Random valid_in gaps inside locked frames -> boundaries track valid-bit count only, lock kept; sys_rst pulse mid-frame -> outputs 0 same cycle, no hit for next 31 valid bits.
